// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for the serial
// arithmetic blocks and a counter-width helper.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2, never less than one bit so a counter always exists.
  function automatic int cnt_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
// Shared between the serial and ripple subtractors.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell and
// a registered borrow. start/busy/done handshake; DIFF/Bout hold between
// operations. Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor_1bit u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The new difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = {cell_d, res[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept start only in IDLE, leave RUN after the MSB bit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: handshake flags come straight from the state.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Datapath: capture, shift one bit per RUN cycle, publish result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      DIFF   <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      OVF    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh_a   <= A;
            sh_b   <= B;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          res    <= res_nxt;
          borrow <= cell_bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            DIFF <= res_nxt;
            Bout <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
            // The last cell output is the sign bit of the difference.
            OVF  <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases,
// ignored start, mid-run reset and a held-start random regression.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] DIFF;
  logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .DIFF  (DIFF),
    .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One complete operation with start pulsed for a single cycle.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n;
    int nb;
    logic moved;
    logic [W-1:0] hold;
    logic [W-1:0] ed;
    logic eb;
    ed = a - b;
    eb = (a < b);
    n = 0;
    nb = 0;
    moved = 1'b0;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    hold = DIFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) begin
        nb++;
        if (DIFF !== hold) moved = 1'b1;
      end
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_busy_cycles"}, nb, 8);
    check({tag, "_diff_stable_in_run"}, {31'd0, moved}, 0);
    check({tag, "_diff"}, {24'd0, DIFF}, {24'd0, ed});
    check({tag, "_bout"}, {31'd0, Bout}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, {31'd0, OVF}, {31'd0, ((a[W-1] ^ b[W-1]) & (a[W-1] ^ ed[W-1]))});
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
    check({tag, "_diff_hold"}, {24'd0, DIFF}, {24'd0, ed});
  endtask

  initial begin
    int n;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ea;
    logic [W-1:0] eb;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_diff", {24'd0, DIFF}, 0);
    check("reset_bout", {31'd0, Bout}, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", {31'd0, OVF}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, including A==B and the 0 - all-ones corner.
    op(8'h5A, 8'h23, "op_5a_23");
    op(8'h10, 8'h20, "op_10_20");
    op(8'h00, 8'h01, "op_00_01");
    op(8'hFF, 8'hFF, "op_ff_ff");
    op(8'h00, 8'hFF, "op_00_ff");
    op(8'h80, 8'h01, "op_80_01");
    op(8'h7F, 8'hFF, "op_7f_ff");
    op(8'h05, 8'h03, "op_05_03");

    // start held through RUN with operands changed: exactly one result.
    @(negedge clk);
    A = 8'h40;
    B = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 8'h00;
    B = 8'h00;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_latency", n, 9);
    check("hold_diff", {24'd0, DIFF}, 32'h3F);
    check("hold_bout", {31'd0, Bout}, 0);
    start = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("hold_no_second_op", seen, 0);
    check("hold_diff_kept", {24'd0, DIFF}, 32'h3F);

    // Reset in the fourth RUN cycle discards the operation.
    @(negedge clk);
    A = 8'h80;
    B = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_done", {31'd0, done}, 0);
    check("rst_mid_diff", {24'd0, DIFF}, 0);
    check("rst_mid_bout", {31'd0, Bout}, 0);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_mid_no_done", seen, 0);
    op(8'h80, 8'h01, "after_rst");

    // Random back-to-back regression with start held high.
    ra = W'($urandom);
    rb = W'($urandom);
    @(negedge clk);
    A = ra;
    B = rb;
    start = 1'b1;
    qa.push_back(ra);
    qb.push_back(rb);
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 30);
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("rand_spacing", n, (i == 0) ? 9 : 10);
      check("rand_diff", {24'd0, DIFF}, {24'd0, W'(ea - eb)});
      check("rand_bout", {31'd0, Bout}, {31'd0, (ea < eb)});
      if (i < 999) begin
        ra = W'($urandom);
        rb = W'($urandom);
        A = ra;
        B = rb;
        qa.push_back(ra);
        qb.push_back(rb);
      end else begin
        start = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
